// File: rtl/lc3b_types.sv
// lc3b_types: shared state type for the memory arbiter
package lc3b_types;
  typedef enum logic {IDLE, BUSY} mem_arb_state;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick; req_i/rr_ptr_i in, grant_o/any_req_o out
module rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IW-1:0]        rr_ptr_i,
  output logic [IW-1:0]        grant_o,
  output logic                 any_req_o
);
  logic [IW-1:0] idx;
  assign any_req_o = |req_i;
  always_comb begin
    grant_o = '0;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr_i) + i) % NUM_PORTS);
      grant_o = req_i[idx] ? idx : grant_o;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of NUM_PORTS masters onto one memory port
// ports: clk/rst; port_read/write/address/wdata/byte_enable in, port_resp/rdata out;
//        mem_read/write/address/wdata/byte_enable out, mem_resp/rdata in
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  port_read,
  input  logic [NUM_PORTS-1:0]                  port_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  port_address,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  port_wdata,
  input  logic [NUM_PORTS-1:0][MASK_WIDTH-1:0]  port_byte_enable,
  output logic [NUM_PORTS-1:0]                  port_resp,
  output logic [DATA_WIDTH-1:0]                 port_rdata,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic [ADDR_WIDTH-1:0]                 mem_address,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  output logic [MASK_WIDTH-1:0]                 mem_byte_enable,
  input  logic                                  mem_resp,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata
);
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  mem_arb_state state_q;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_q, pick;
  logic any_req, done;
  rr_picker #(.NUM_PORTS(NUM_PORTS), .IW(IW)) u_pick (
    .req_i(port_read | port_write),
    .rr_ptr_i(rr_ptr_q),
    .grant_o(pick),
    .any_req_o(any_req)
  );
  // a reset landing on the completion cycle abandons the transaction
  assign done = state_q == BUSY && mem_resp && !rst;
  assign port_resp = done ? NUM_PORTS'(1) << grant_q : '0;
  assign port_rdata = mem_rdata;
  assign rr_ptr_d = grant_q == IW'(NUM_PORTS - 1) ? '0 : grant_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_q <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= '0;
      mem_wdata <= '0;
      mem_byte_enable <= '0;
    end else if (state_q == IDLE) begin
      if (any_req) begin
        state_q <= BUSY;
        grant_q <= pick;
        mem_address <= port_address[pick];
        mem_wdata <= port_wdata[pick];
        mem_byte_enable <= port_byte_enable[pick];
        mem_write <= port_write[pick];
        mem_read <= !port_write[pick];
      end
    end else if (mem_resp) begin
      state_q <= IDLE;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for 2-port and 4-port arbiters
module tb_mem_arbiter;
  logic clk;
  logic a_rst, b_rst;
  logic [1:0] a_rd, a_wr, a_presp;
  logic [1:0][15:0] a_addr, a_wdata;
  logic [1:0][1:0] a_be;
  logic [15:0] a_prdata, a_maddr, a_mwdata, a_mrdata;
  logic a_mrd, a_mwr, a_mresp;
  logic [1:0] a_mbe;
  logic [3:0] b_rd, b_wr, b_presp;
  logic [3:0][15:0] b_addr, b_wdata;
  logic [3:0][1:0] b_be;
  logic [15:0] b_prdata, b_maddr, b_mwdata, b_mrdata;
  logic b_mrd, b_mwr, b_mresp;
  logic [1:0] b_mbe;
  int passed = 0, total = 0, failed = 0;

  mem_arbiter u_a (
    .clk(clk), .rst(a_rst), .port_read(a_rd), .port_write(a_wr),
    .port_address(a_addr), .port_wdata(a_wdata), .port_byte_enable(a_be),
    .port_resp(a_presp), .port_rdata(a_prdata), .mem_read(a_mrd), .mem_write(a_mwr),
    .mem_address(a_maddr), .mem_wdata(a_mwdata), .mem_byte_enable(a_mbe),
    .mem_resp(a_mresp), .mem_rdata(a_mrdata)
  );

  mem_arbiter #(.NUM_PORTS(4)) u_b (
    .clk(clk), .rst(b_rst), .port_read(b_rd), .port_write(b_wr),
    .port_address(b_addr), .port_wdata(b_wdata), .port_byte_enable(b_be),
    .port_resp(b_presp), .port_rdata(b_prdata), .mem_read(b_mrd), .mem_write(b_mwr),
    .mem_address(b_maddr), .mem_wdata(b_mwdata), .mem_byte_enable(b_mbe),
    .mem_resp(b_mresp), .mem_rdata(b_mrdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_rst = 1; b_rst = 1;
    a_rd = '0; a_wr = '0; a_addr = '0; a_wdata = '0; a_be = '0; a_mresp = 0; a_mrdata = '0;
    b_rd = '0; b_wr = '0; b_addr = '0; b_wdata = '0; b_be = '0; b_mresp = 0; b_mrdata = '0;
    tick; tick;
    chk("rst_mem_read", a_mrd, 0);
    chk("rst_mem_write", a_mwr, 0);
    chk("rst_mem_address", a_maddr, 0);
    chk("rst_mem_wdata", a_mwdata, 0);
    chk("rst_mem_be", a_mbe, 0);
    chk("rst_port_resp", a_presp, 0);
    chk("rst_b_port_resp", b_presp, 0);
    a_rst = 0; b_rst = 0;
    a_rd[0] = 1; a_addr[0] = 16'h1234;
    tick;
    chk("rd_mem_read", a_mrd, 1);
    chk("rd_mem_write", a_mwr, 0);
    chk("rd_addr", a_maddr, 16'h1234);
    chk("rd_no_resp", a_presp, 0);
    tick; tick;
    chk("rd_hold", a_mrd, 1);
    chk("rd_hold_no_resp", a_presp, 0);
    a_mresp = 1; a_mrdata = 16'hBEEF; #1;
    chk("rd_resp", a_presp, 2'b01);
    chk("rd_rdata", a_prdata, 16'hBEEF);
    tick;
    a_mresp = 0; a_rd = '0; #1;
    chk("rd_done_mem_read", a_mrd, 0);
    chk("rd_done_resp", a_presp, 0);
    a_wr[1] = 1; a_addr[1] = 16'h0040; a_wdata[1] = 16'hA5A5; a_be[1] = 2'b10;
    tick;
    chk("wr_mem_write", a_mwr, 1);
    chk("wr_mem_read", a_mrd, 0);
    chk("wr_wdata", a_mwdata, 16'hA5A5);
    chk("wr_be", a_mbe, 2'b10);
    chk("wr_addr", a_maddr, 16'h0040);
    a_wdata[1] = '0; a_addr[1] = 16'hFFFF; a_be[1] = 2'b01;
    tick;
    chk("wr_stable_wdata", a_mwdata, 16'hA5A5);
    chk("wr_stable_addr", a_maddr, 16'h0040);
    chk("wr_stable_be", a_mbe, 2'b10);
    chk("wr_stable_write", a_mwr, 1);
    chk("wr_no_resp", a_presp, 0);
    a_mresp = 1; #1;
    chk("wr_resp", a_presp, 2'b10);
    tick;
    a_mresp = 0; a_wr = '0; #1;
    a_rd[0] = 1; a_wr[0] = 1; a_wdata[0] = 16'h1111; a_be[0] = 2'b11;
    tick;
    chk("rw_mem_write", a_mwr, 1);
    chk("rw_mem_read", a_mrd, 0);
    chk("rw_wdata", a_mwdata, 16'h1111);
    a_mresp = 1; #1;
    chk("rw_resp", a_presp, 2'b01);
    tick;
    a_mresp = 0; a_rd = '0; a_wr = '0;
    a_rst = 1;
    tick;
    a_rst = 0; a_rd = 2'b11; a_addr[0] = 16'h0100; a_addr[1] = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("cont_addr", a_maddr, (i % 2) ? 16'h0200 : 16'h0100);
      a_mresp = 1; #1;
      chk("cont_resp", a_presp, (i % 2) ? 2'b10 : 2'b01);
      tick;
      a_mresp = 0; #1;
      chk("cont_idle_resp", a_presp, 0);
    end
    tick;
    chk("mid_grant0", a_maddr, 16'h0100);
    a_mresp = 1;
    tick;
    a_mresp = 0;
    tick;
    chk("mid_grant1", a_maddr, 16'h0200);
    a_rst = 1; a_mresp = 1; #1;
    chk("mid_rst_no_resp", a_presp, 0);
    tick;
    a_rst = 0; a_mresp = 0; #1;
    chk("mid_rst_mem_read", a_mrd, 0);
    chk("mid_rst_addr", a_maddr, 0);
    tick;
    chk("mid_next_grant", a_maddr, 16'h0100);
    chk("mid_next_read", a_mrd, 1);
    a_mresp = 1; #1;
    chk("mid_next_resp", a_presp, 2'b01);
    tick;
    a_mresp = 0; a_rd = '0;
    b_mresp = 1; #1;
    chk("b_stray_resp", b_presp, 0);
    tick;
    chk("b_stray_mem_read", b_mrd, 0);
    chk("b_stray_resp_after", b_presp, 0);
    b_mresp = 0;
    b_rd = 4'b1010; b_addr[1] = 16'h0011; b_addr[3] = 16'h0033;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("b_cont_addr", b_maddr, (i % 2) ? 16'h0033 : 16'h0011);
      b_mresp = 1; #1;
      chk("b_cont_resp", b_presp, (i % 2) ? 4'b1000 : 4'b0010);
      tick;
      b_mresp = 0; #1;
    end
    b_mrdata = 16'h5A5A; #1;
    chk("b_rdata_pass", b_prdata, 16'h5A5A);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
